// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one start/done multiplier among NREQ requesters.
// Optional BUSY watchdog enabled by defining MUL_SHARE_ARBITER_TIMEOUT_EN.
module mul_share_arbiter #(
  parameter int N       = 32,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [N-1:0]        mul_a,
  output logic [N-1:0]        mul_b,
  output logic                mul_en,
  input  logic                mul_done,
  input  logic [2*N-1:0]      mul_result,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [2*N-1:0]      resp_result,
  output logic                resp_err,
  output logic                busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TIMEOUT < 1) begin : g_param_check
    $error("mul_share_arbiter: illegal parameter combination");
  end

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [N-1:0]   mul_a_q, mul_a_d;
  logic [N-1:0]   mul_b_q, mul_b_d;
  logic [2*N-1:0] resp_result_q, resp_result_d;

  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic [N-1:0]    gnt_a, gnt_b;

`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
  localparam int             CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          resp_err_q, resp_err_d;
`endif

  // Two passes: indices above rr_ptr first, then wrap to indices at or below it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    gnt_a   = '0;
    gnt_b   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_vld && req_valid[i] && (i > 32'(rr_ptr_q))) begin
        gnt_vld    = 1'b1;
        gnt_idx    = IDW'(i);
        gnt_oh[i]  = 1'b1;
        gnt_a      = req_a[i*N +: N];
        gnt_b      = req_b[i*N +: N];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_vld && req_valid[i] && (i <= 32'(rr_ptr_q))) begin
        gnt_vld    = 1'b1;
        gnt_idx    = IDW'(i);
        gnt_oh[i]  = 1'b1;
        gnt_a      = req_a[i*N +: N];
        gnt_b      = req_b[i*N +: N];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    resp_id_d     = resp_id_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    resp_result_d = resp_result_q;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    resp_err_d    = resp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          mul_a_d   = gnt_a;
          mul_b_d   = gnt_b;
          resp_id_d = gnt_idx;
          rr_ptr_d  = gnt_idx;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        state_d = BUSY;
      end
      BUSY: begin
        if (mul_done) begin
          resp_result_d = mul_result;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
          resp_err_d    = 1'b0;
`endif
          state_d       = RESP;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
        end else if (to_cnt_q == TO_LAST) begin
          resp_result_d = '0;
          resp_err_d    = 1'b1;
          state_d       = RESP;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
`endif
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= IDW'(NREQ - 1);
      resp_id_q     <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      resp_result_q <= '0;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
      to_cnt_q      <= '0;
      resp_err_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      resp_id_q     <= resp_id_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      resp_result_q <= resp_result_d;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      resp_err_q    <= resp_err_d;
`endif
    end
  end

  // Grant is gated by reset so every output reads 0 while reset is held.
  assign req_ready   = (state_q == IDLE && reset) ? gnt_oh : '0;
  assign mul_en      = (state_q == ISSUE);
  assign resp_valid  = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
  assign resp_err    = resp_err_q;
`else
  assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed + randomized bench for mul_share_arbiter with a behavioural multiplier and grant model.
// Timeout scenario runs only when MUL_SHARE_ARBITER_TIMEOUT_EN is defined.
module tb_mul_share_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TO   = 64;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic [N-1:0]      mul_a, mul_b;
  logic              mul_en;
  logic              mul_done;
  logic [2*N-1:0]    mul_result;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [2*N-1:0]    resp_result;
  logic              resp_err;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] opa [NREQ];
  logic [N-1:0] opb [NREQ];
  int last_grant;
  int lat_cfg  = 17;
  bit withhold = 0;

  mul_share_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en),
    .mul_done(mul_done), .mul_result(mul_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_err(resp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: done strobe lat_cfg cycles after the start strobe.
  initial begin
    bit              pend;
    int              rem;
    logic [2*N-1:0]  prod;
    pend = 0; rem = 0; prod = '0;
    mul_done = 1'b0; mul_result = '0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (!reset) begin
        pend = 0;
      end else begin
        if (pend) begin
          rem--;
          if (rem == 0) begin
            pend = 0;
            if (!withhold) begin
              mul_done   = 1'b1;
              mul_result = prod;
            end
          end
        end
        if (mul_en) begin
          pend = 1;
          rem  = lat_cfg;
          prod = $signed({{N{mul_a[N-1]}}, mul_a}) * $signed({{N{mul_b[N-1]}}, mul_b});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] m, input int prev);
    for (int d = 1; d <= NREQ; d++)
      if (m[(prev + d) % NREQ]) return (prev + d) % NREQ;
    return -1;
  endfunction

  function automatic logic [63:0] ref_prod(input logic [N-1:0] a, input logic [N-1:0] b);
    longint sa, sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    return 64'(sa * sb);
  endfunction

  task automatic load_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = opa[i];
      req_b[i*N +: N] = opb[i];
    end
  endtask

  // Entered and left at negedge+1 with the DUT in IDLE.
  task automatic run_op(input logic [NREQ-1:0] mask, input int lat, input int hold);
    int g;
    logic [63:0] exp_res;
    lat_cfg = lat;
    load_ops();
    req_valid = mask;
    #1;
    g = model_grant(mask, last_grant);
    check("req_ready_grant", 64'(req_ready), 64'(1 << g));
    check("busy_idle", 64'(busy), 64'd0);
    last_grant = g;
    exp_res = ref_prod(opa[g], opb[g]);
    @(negedge clk); #1;
    check("mul_en_issue", 64'(mul_en), 64'd1);
    check("mul_a", 64'(mul_a), 64'(opa[g]));
    check("mul_b", 64'(mul_b), 64'(opb[g]));
    check("req_ready_issue", 64'(req_ready), 64'd0);
    @(negedge clk); #1;
    check("mul_en_pulse", 64'(mul_en), 64'd0);
    for (int c = 0; c < lat + 4 && resp_valid !== 1'b1; c++) begin
      @(negedge clk); #1;
    end
    check("resp_valid_wait", 64'(resp_valid), 64'd1);
    check("resp_id", 64'(resp_id), 64'(g));
    check("resp_result", resp_result, exp_res);
    check("resp_err", 64'(resp_err), 64'd0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk); #1;
      check("bp_resp_valid", 64'(resp_valid), 64'd1);
      check("bp_resp_id", 64'(resp_id), 64'(g));
      check("bp_resp_result", resp_result, exp_res);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_mul_en", 64'(mul_en), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk); #1;
    resp_ready = 1'b0;
    check("resp_valid_drop", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    last_grant = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end

    @(negedge clk); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mul_en", 64'(mul_en), 64'd0);
    check("rst_resp_result", resp_result, 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    reset = 1'b1;

    // Round robin with all requesters held active.
    for (int i = 0; i < NREQ; i++) begin opa[i] = N'(i * 10); opb[i] = N'(2); end
    for (int k = 0; k < 5; k++) run_op(4'b1111, 3, 0);

    // No request: stays idle.
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("idle_req_ready", 64'(req_ready), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end

    // Single request, 17-cycle multiplier, then backpressure for 10 cycles.
    opa[0] = 32'd7; opb[0] = -32'sd3;
    run_op(4'b0001, 17, 0);
    run_op(4'b0001, 17, 10);

    // Edge operands.
    opa[0] = 32'h8000_0000; opb[0] = 32'h8000_0000;
    run_op(4'b0001, 5, 1);
    opa[0] = 32'hFFFF_FFFF; opb[0] = 32'd1;
    run_op(4'b0001, 1, 0);

    // Randomized operands, request sets, latencies and response waits.
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < NREQ; i++) begin opa[i] = $urandom; opb[i] = $urandom; end
      run_op(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(1, 20), $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of BUSY.
    req_valid = 4'b0100; lat_cfg = 17; load_ops();
    @(negedge clk); #1;
    check("ar_mul_en", 64'(mul_en), 64'd1);
    @(negedge clk); @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_mul_en0", 64'(mul_en), 64'd0);
    check("ar_mul_a", 64'(mul_a), 64'd0);
    check("ar_mul_b", 64'(mul_b), 64'd0);
    check("ar_req_ready", 64'(req_ready), 64'd0);
    check("ar_resp_valid", 64'(resp_valid), 64'd0);
    check("ar_resp_id", 64'(resp_id), 64'd0);
    check("ar_resp_result", resp_result, 64'd0);
    check("ar_resp_err", 64'(resp_err), 64'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    last_grant = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin opa[i] = N'(i + 3); opb[i] = N'(5); end
    run_op(4'b1111, 4, 0);

`ifdef MUL_SHARE_ARBITER_TIMEOUT_EN
    begin
      int g;
      withhold = 1; lat_cfg = 5;
      req_valid = 4'b0010; load_ops();
      #1;
      g = model_grant(4'b0010, last_grant);
      check("to_grant", 64'(req_ready), 64'(1 << g));
      last_grant = g;
      @(negedge clk); #1;
      check("to_mul_en", 64'(mul_en), 64'd1);
      for (int c = 1; c <= TO; c++) begin
        @(negedge clk); #1;
      end
      check("to_not_early", 64'(resp_valid), 64'd0);
      @(negedge clk); #1;
      check("to_resp_valid", 64'(resp_valid), 64'd1);
      check("to_resp_err", 64'(resp_err), 64'd1);
      check("to_resp_result", resp_result, 64'd0);
      check("to_resp_id", 64'(resp_id), 64'(g));
      resp_ready = 1'b1;
      @(negedge clk); #1;
      resp_ready = 1'b0;
      withhold = 0;
      run_op(4'b0010, 6, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
